// File: rtl/multicycle_subtractor_pkg.sv
// multicycle_sub_pkg: shared slice width and FSM encoding for the multicycle subtractor
package multicycle_sub_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multicycle_subtractor_if.sv
// multicycle_subtractor_if: operand and result valid/ready handshakes
interface multicycle_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             v;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, v);
  modport slave (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, v);
endinterface

// File: rtl/multicycle_subtractor_cla4_slice.sv
// cla4_slice: 4-bit carry-lookahead adder slice with explicit generate/propagate terms
module cla4_slice
  import multicycle_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/multicycle_subtractor.sv
// multicycle_subtractor: a - b - bin computed one 4-bit CLA slice per cycle
module multicycle_subtractor
  import multicycle_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clock,
  input logic reset,
  multicycle_subtractor_if.slave bus
);
  localparam int S  = WIDTH / SLICE_W;
  localparam int KW = (S > 1) ? $clog2(S) : 1;
  state_t state_q, state_d;
  logic [KW-1:0]      k_q;
  logic [WIDTH-1:0]   a_q, b_q, diff_q;
  logic               borrow_q, v_q;
  logic [SLICE_W-1:0] s4;
  logic               c4, last, accept;
  // subtraction as a + ~b + ~borrow on the shared slice
  cla4_slice u_slice (
    .a    (a_q[SLICE_W*k_q +: SLICE_W]),
    .b    (~b_q[SLICE_W*k_q +: SLICE_W]),
    .cin  (~borrow_q),
    .sum  (s4),
    .cout (c4)
  );
  assign last   = (k_q == KW'(S - 1));
  assign accept = (state_q == IDLE) && bus.in_valid;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (bus.in_valid ? RUN : IDLE)
            : (state_q == RUN)  ? (last ? DONE : RUN)
            : (state_q == DONE) ? (bus.out_ready ? IDLE : DONE)
            : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        borrow_q <= bus.bin;
        k_q      <= '0;
      end else if (state_q == RUN) begin
        borrow_q <= ~c4;
        diff_q   <= WIDTH'({s4, diff_q} >> SLICE_W);
        k_q      <= last ? '0 : k_q + 1'b1;
        if (last) v_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s4[SLICE_W-1] != a_q[WIDTH-1]);
      end
    end
  end
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = borrow_q;
  assign bus.v         = v_q;
endmodule

// File: tb/tb_multicycle_subtractor.sv
// tb_multicycle_subtractor: directed vectors with hand-computed results and handshake timing
module tb_multicycle_subtractor;
  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  multicycle_subtractor_if #(.WIDTH(16)) bus ();
  multicycle_subtractor #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic ev);
    int lat;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
    check({tag, "_v"}, 32'(bus.v), 32'(ev));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask
  logic [15:0] va [3] = '{16'hABCD, 16'h7FFF, 16'h0F0F};
  logic [15:0] vb [3] = '{16'h1234, 16'hFFFF, 16'hF0F0};
  logic        vc [3] = '{1'b1, 1'b0, 1'b1};
  int acc_t [3];
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    check("rst_v", 32'(bus.v), 32'd0);
    run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("ripple", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    run_op("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op("bin", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    // hold the result under backpressure while new operands knock
    bus.a = 16'h1234;
    bus.b = 16'h0034;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.a = 16'hFFFF;
    bus.b = 16'h0000;
    bus.bin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      tick();
      check("bp_diff", 32'(bus.diff), 32'h1200);
      check("bp_bout", 32'(bus.bout), 32'd0);
      check("bp_v", 32'(bus.v), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_no_capture", 32'(bus.out_valid), 32'd0);
    // abort after two RUN slices
    bus.a = 16'h1234;
    bus.b = 16'h0001;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("post_abort", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    // back-to-back with reference model
    begin
      int cyc = 0, n_acc = 0, n_res = 0;
      logic acc;
      logic [16:0] r;
      bus.a = va[0];
      bus.b = vb[0];
      bus.bin = vc[0];
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      while (n_res < 3 && cyc < 60) begin
        acc = bus.in_ready && bus.in_valid;
        if (bus.out_valid) begin
          r = {1'b0, va[n_res]} - {1'b0, vb[n_res]} - 17'(vc[n_res]);
          check("b2b_diff", 32'(bus.diff), 32'(r[15:0]));
          check("b2b_bout", 32'(bus.bout), 32'(r[16]));
          check("b2b_v", 32'(bus.v), 32'((va[n_res][15] != vb[n_res][15]) && (r[15] != va[n_res][15])));
          n_res++;
        end
        tick();
        cyc++;
        if (acc && n_acc < 3) begin
          acc_t[n_acc] = cyc;
          n_acc++;
          if (n_acc < 3) begin
            bus.a = va[n_acc];
            bus.b = vb[n_acc];
            bus.bin = vc[n_acc];
          end else bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      check("b2b_results", 32'(n_res), 32'd3);
      check("b2b_accepts", 32'(n_acc), 32'd3);
      check("b2b_ii_1", 32'(acc_t[1] - acc_t[0]), 32'd6);
      check("b2b_ii_2", 32'(acc_t[2] - acc_t[1]), 32'd6);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
